// File: rtl/axi2ahb_pkg.sv
// Shared types and constants for the AXI-to-AHB command arbiter.
package axi2ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    ISSUE  = 2'd2,
    WAIT_B = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic       GNT_RD    = 1'b0;
  localparam logic       GNT_WR    = 1'b1;

endpackage

// File: rtl/axi2ahb_rr_arb2.sv
// Two-requester round-robin picker: req[0]=read, req[1]=write.
module axi2ahb_rr_arb2
  import axi2ahb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    grant = GNT_RD;
    case (req)
      2'b10:   grant = GNT_WR;
      2'b11:   grant = ~last_grant;
      default: grant = GNT_RD;
    endcase
  end

endmodule

// File: rtl/axi2ahb_cmd_arb.sv
// Round-robin AW/AR command arbiter, one command in flight, with B response generation.
// Optional grant counters are enabled with AXI2AHB_ARB_STATS_EN.
module axi2ahb_cmd_arb
  import axi2ahb_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 8
`ifdef AXI2AHB_ARB_STATS_EN
  , parameter int STAT_WIDTH = 16
`endif
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]                AWLEN,
  input  logic [1:0]                AWBURST,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  input  logic [AXI_ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]                ARLEN,
  input  logic [1:0]                ARBURST,
  output logic                      BVALID,
  input  logic                      BREADY,
  output logic [1:0]                BRESP,
  output logic                      cmd_read_o,
  output logic                      cmd_write_o,
  output logic [AXI_ADDR_WIDTH-1:0] cmd_start_addr_o,
  output logic [7:0]                cmd_transfer_len_o,
  output logic [1:0]                cmd_burst_type_o,
  output logic                      ctrl_cmd_valid_o,
  input  logic                      ctrl_cmd_ready_i
`ifdef AXI2AHB_ARB_STATS_EN
  , output logic [STAT_WIDTH-1:0]   stat_rd_cnt_o
  , output logic [STAT_WIDTH-1:0]   stat_wr_cnt_o
`endif
);

  // state  | meaning
  // IDLE   | no command; pick a requester when any AxVALID is up
  // ACCEPT | winner's AxREADY high; capture command
  // ISSUE  | command offered to controller until its ready pulse
  // WAIT_B | write done, BVALID held until BREADY
  arb_state_e state;
  logic       last_grant;
  logic       grant_q;
  logic       arb_grant;

  axi2ahb_rr_arb2 u_rr (
    .req        ({AWVALID, ARVALID}),
    .last_grant (last_grant),
    .grant      (arb_grant)
  );

  assign BRESP = RESP_OKAY;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state              <= IDLE;
      last_grant         <= GNT_WR;
      grant_q            <= GNT_RD;
      ARREADY            <= 1'b0;
      AWREADY            <= 1'b0;
      BVALID             <= 1'b0;
      cmd_read_o         <= 1'b0;
      cmd_write_o        <= 1'b0;
      cmd_start_addr_o   <= '0;
      cmd_transfer_len_o <= '0;
      cmd_burst_type_o   <= '0;
      ctrl_cmd_valid_o   <= 1'b0;
`ifdef AXI2AHB_ARB_STATS_EN
      stat_rd_cnt_o      <= '0;
      stat_wr_cnt_o      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ARVALID || AWVALID) begin
            grant_q <= arb_grant;
            ARREADY <= (arb_grant == GNT_RD);
            AWREADY <= (arb_grant == GNT_WR);
            state   <= ACCEPT;
          end
        end
        ACCEPT: begin
          // VALID cannot drop before handshake, so the captured channel is live here.
          ARREADY          <= 1'b0;
          AWREADY          <= 1'b0;
          last_grant       <= grant_q;
          ctrl_cmd_valid_o <= 1'b1;
          if (grant_q == GNT_RD) begin
            cmd_read_o         <= 1'b1;
            cmd_start_addr_o   <= ARADDR;
            cmd_transfer_len_o <= ARLEN;
            cmd_burst_type_o   <= ARBURST;
`ifdef AXI2AHB_ARB_STATS_EN
            stat_rd_cnt_o      <= stat_rd_cnt_o + 1'b1;
`endif
          end else begin
            cmd_write_o        <= 1'b1;
            cmd_start_addr_o   <= AWADDR;
            cmd_transfer_len_o <= AWLEN;
            cmd_burst_type_o   <= AWBURST;
`ifdef AXI2AHB_ARB_STATS_EN
            stat_wr_cnt_o      <= stat_wr_cnt_o + 1'b1;
`endif
          end
          state <= ISSUE;
        end
        ISSUE: begin
          if (ctrl_cmd_ready_i) begin
            ctrl_cmd_valid_o <= 1'b0;
            if (cmd_write_o) begin
              BVALID <= 1'b1;
              state  <= WAIT_B;
            end else begin
              cmd_read_o <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        WAIT_B: begin
          if (BREADY) begin
            BVALID      <= 1'b0;
            cmd_write_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi2ahb_cmd_arb.sv
// Bench for axi2ahb_cmd_arb: directed scenarios plus randomized commands against a queue-free transaction model.
module tb_axi2ahb_cmd_arb;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic       AWVALID, AWREADY, ARVALID, ARREADY;
  logic [7:0] AWADDR, ARADDR, AWLEN, ARLEN;
  logic [1:0] AWBURST, ARBURST, BRESP;
  logic       BVALID, BREADY;
  logic       cmd_read_o, cmd_write_o, ctrl_cmd_valid_o, ctrl_cmd_ready_i;
  logic [7:0] cmd_start_addr_o, cmd_transfer_len_o;
  logic [1:0] cmd_burst_type_o;
`ifdef AXI2AHB_ARB_STATS_EN
  logic [15:0] stat_rd_cnt_o, stat_wr_cnt_o;
`endif

  axi2ahb_cmd_arb #(.AXI_ADDR_WIDTH(8)) dut (
    .ACLK               (ACLK),
    .ARESET             (ARESET),
    .AWVALID            (AWVALID),
    .AWREADY            (AWREADY),
    .AWADDR             (AWADDR),
    .AWLEN              (AWLEN),
    .AWBURST            (AWBURST),
    .ARVALID            (ARVALID),
    .ARREADY            (ARREADY),
    .ARADDR             (ARADDR),
    .ARLEN              (ARLEN),
    .ARBURST            (ARBURST),
    .BVALID             (BVALID),
    .BREADY             (BREADY),
    .BRESP              (BRESP),
    .cmd_read_o         (cmd_read_o),
    .cmd_write_o        (cmd_write_o),
    .cmd_start_addr_o   (cmd_start_addr_o),
    .cmd_transfer_len_o (cmd_transfer_len_o),
    .cmd_burst_type_o   (cmd_burst_type_o),
    .ctrl_cmd_valid_o   (ctrl_cmd_valid_o),
    .ctrl_cmd_ready_i   (ctrl_cmd_ready_i)
`ifdef AXI2AHB_ARB_STATS_EN
    , .stat_rd_cnt_o    (stat_rd_cnt_o)
    , .stat_wr_cnt_o    (stat_wr_cnt_o)
`endif
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_mis = 0;

  // Transaction-level model: who is waiting, who was served last, what is in flight.
  bit         exp_last;
  bit         pend_ar, pend_aw;
  logic [7:0] ar_addr_m, ar_len_m, aw_addr_m, aw_len_m;
  logic [1:0] ar_burst_m, aw_burst_m;
  logic [7:0] e_addr, e_len;
  logic [1:0] e_burst;
  int         rd_cnt, wr_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_ar(input logic [7:0] a, input logic [7:0] l, input logic [1:0] b);
    if (!pend_ar) begin
      ar_addr_m = a; ar_len_m = l; ar_burst_m = b;
      ARADDR = a; ARLEN = l; ARBURST = b; ARVALID = 1'b1;
      pend_ar = 1'b1;
    end
  endtask

  task automatic set_aw(input logic [7:0] a, input logic [7:0] l, input logic [1:0] b);
    if (!pend_aw) begin
      aw_addr_m = a; aw_len_m = l; aw_burst_m = b;
      AWADDR = a; AWLEN = l; AWBURST = b; AWVALID = 1'b1;
      pend_aw = 1'b1;
    end
  endtask

  task automatic issue_checks(input bit win);
    @(negedge ACLK);
    chk("issue_valid", ctrl_cmd_valid_o, 1);
    chk("issue_read", cmd_read_o, !win);
    chk("issue_write", cmd_write_o, win);
    chk("issue_addr", cmd_start_addr_o, e_addr);
    chk("issue_len", cmd_transfer_len_o, e_len);
    chk("issue_burst", cmd_burst_type_o, e_burst);
    chk("issue_arready", ARREADY, 0);
    chk("issue_awready", AWREADY, 0);
    chk("issue_bvalid", BVALID, 0);
  endtask

  // Called at posedge+1 of an IDLE cycle with at least one request pending.
  task automatic run_cmd(input int issue_wait, input int b_wait, input bit inject);
    bit win;
    win = (pend_ar && pend_aw) ? !exp_last : pend_aw;
    @(negedge ACLK);
    chk("idle_arready", ARREADY, 0);
    chk("idle_awready", AWREADY, 0);
    chk("idle_valid", ctrl_cmd_valid_o, 0);
    chk("idle_read", cmd_read_o, 0);
    chk("idle_write", cmd_write_o, 0);
    chk("idle_bvalid", BVALID, 0);
    chk("idle_addr_held", cmd_start_addr_o, e_addr);
    tick();
    @(negedge ACLK);
    chk("acc_arready", ARREADY, !win);
    chk("acc_awready", AWREADY, win);
    chk("acc_valid", ctrl_cmd_valid_o, 0);
    tick();
    if (!win) begin
      e_addr = ar_addr_m; e_len = ar_len_m; e_burst = ar_burst_m;
      ARVALID = 1'b0; pend_ar = 1'b0; ARADDR = 8'($urandom); ARLEN = 8'($urandom);
      rd_cnt++;
    end else begin
      e_addr = aw_addr_m; e_len = aw_len_m; e_burst = aw_burst_m;
      AWVALID = 1'b0; pend_aw = 1'b0; AWADDR = 8'($urandom); AWLEN = 8'($urandom);
      wr_cnt++;
    end
    exp_last = win;
    if (inject) set_aw(8'($urandom), 8'($urandom), 2'($urandom_range(0, 2)));
    repeat (issue_wait) begin
      issue_checks(win);
      tick();
    end
    ctrl_cmd_ready_i = 1'b1;
    issue_checks(win);
    tick();
    ctrl_cmd_ready_i = 1'b0;
    if (win) begin
      @(negedge ACLK);
      chk("wb_bvalid", BVALID, 1);
      chk("wb_bresp", BRESP, 0);
      chk("wb_valid_drop", ctrl_cmd_valid_o, 0);
      chk("wb_write_held", cmd_write_o, 1);
      chk("wb_addr_held", cmd_start_addr_o, e_addr);
      tick();
      repeat (b_wait) begin
        ctrl_cmd_ready_i = 1'($urandom);
        @(negedge ACLK);
        chk("wb_bvalid_hold", BVALID, 1);
        chk("wb_write_hold", cmd_write_o, 1);
        tick();
      end
      ctrl_cmd_ready_i = 1'b0;
      BREADY = 1'b1;
      @(negedge ACLK);
      chk("wb_bvalid_hs", BVALID, 1);
      tick();
      BREADY = 1'b0;
    end
  endtask

  initial begin
    ARESET = 1'b1;
    AWVALID = 0; ARVALID = 0; BREADY = 0; ctrl_cmd_ready_i = 0;
    AWADDR = 0; ARADDR = 0; AWLEN = 0; ARLEN = 0; AWBURST = 0; ARBURST = 0;
    exp_last = 1'b1; pend_ar = 0; pend_aw = 0;
    e_addr = 0; e_len = 0; e_burst = 0; rd_cnt = 0; wr_cnt = 0;
    tick();
    tick();
    @(negedge ACLK);
    chk("rst_arready", ARREADY, 0);
    chk("rst_awready", AWREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_valid", ctrl_cmd_valid_o, 0);
    chk("rst_read", cmd_read_o, 0);
    chk("rst_write", cmd_write_o, 0);
    chk("rst_addr", cmd_start_addr_o, 0);
    chk("rst_len", cmd_transfer_len_o, 0);
    tick();
    ARESET = 1'b0;

    // Single read, then single write with slow BREADY.
    set_ar(8'h10, 8'd3, 2'b01);
    run_cmd(0, 0, 0);
    set_aw(8'h20, 8'd7, 2'b10);
    run_cmd(1, 2, 0);

    // Both channels held: grants must alternate.
    for (int i = 0; i < 4; i++) begin
      set_ar(8'($urandom), 8'($urandom), 2'($urandom_range(0, 2)));
      set_aw(8'($urandom), 8'($urandom), 2'($urandom_range(0, 2)));
      run_cmd($urandom_range(0, 2), $urandom_range(0, 2), 0);
    end
    // Drain whichever is left.
    while (pend_ar || pend_aw) run_cmd(0, 0, 0);

    // Write arriving while a read is in ISSUE must wait.
    set_ar(8'h33, 8'd1, 2'b00);
    run_cmd(3, 0, 1);
    run_cmd(0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) set_ar(8'($urandom), 8'($urandom), 2'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) set_aw(8'($urandom), 8'($urandom), 2'($urandom_range(0, 2)));
      if (!pend_ar && !pend_aw) set_ar(8'($urandom), 8'($urandom), 2'($urandom_range(0, 2)));
      run_cmd($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end
    while (pend_ar || pend_aw) run_cmd(0, 0, 0);

`ifdef AXI2AHB_ARB_STATS_EN
    @(negedge ACLK);
    chk("stat_rd", stat_rd_cnt_o, rd_cnt % 65536);
    chk("stat_wr", stat_wr_cnt_o, wr_cnt % 65536);
    tick();
`endif

    // Reset while waiting for B: everything drops, next tie goes to read.
    set_aw(8'h44, 8'd2, 2'b01);
    tick();
    tick();
    AWVALID = 1'b0; pend_aw = 1'b0;
    ctrl_cmd_ready_i = 1'b1;
    tick();
    ctrl_cmd_ready_i = 1'b0;
    @(negedge ACLK);
    chk("pre_rst_bvalid", BVALID, 1);
    tick();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("mid_rst_bvalid", BVALID, 0);
    chk("mid_rst_valid", ctrl_cmd_valid_o, 0);
    chk("mid_rst_read", cmd_read_o, 0);
    chk("mid_rst_write", cmd_write_o, 0);
`ifdef AXI2AHB_ARB_STATS_EN
    chk("mid_rst_stat_wr", stat_wr_cnt_o, 0);
`endif
    tick();
    exp_last = 1'b1; e_addr = 0; e_len = 0; e_burst = 0; rd_cnt = 0; wr_cnt = 0;
    set_ar(8'h55, 8'd4, 2'b01);
    set_aw(8'h66, 8'd5, 2'b10);
    run_cmd(0, 0, 0);
    chk("post_rst_tie_read", {31'd0, pend_aw}, 1);
    run_cmd(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
